easyaxi_slv_rd: RTL

EASYAXI_SLV_RD -- requirements
Module: easyaxi_slv_rd

---
 rtl/easyaxi_slv_rd.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/easyaxi_slv_rd.sv
// easyaxi_slv_rd: single-outstanding AXI read responder.
// Every beat returns its own byte address as data. A beat is answered with
// SLVERR and zero data when its address is outside the memory window, when
// the transfer size is not the full bus width, or when the burst type is
// WRAP or reserved.
// Optional feature macro: EASYAXI_SLV_RD_DELAY_EN. When defined, a WAIT
// state holds off the first beat for RD_LATENCY cycles (RD_LATENCY >= 1).
module easyaxi_slv_rd #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 64,
  parameter int RD_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axi_mst_arvalid,
  output logic                  axi_mst_arready,
  input  logic [ID_WIDTH-1:0]   axi_mst_arid,
  input  logic [ADDR_WIDTH-1:0] axi_mst_araddr,
  input  logic [7:0]            axi_mst_arlen,
  input  logic [2:0]            axi_mst_arsize,
  input  logic [1:0]            axi_mst_arburst,
  output logic                  axi_mst_rvalid,
  input  logic                  axi_mst_rready,
  output logic [ID_WIDTH-1:0]   axi_mst_rid,
  output logic [DATA_WIDTH-1:0] axi_mst_rdata,
  output logic [1:0]            axi_mst_rresp,
  output logic                  axi_mst_rlast
);

  localparam int                  BYTES       = DATA_WIDTH / 8;
  localparam logic [2:0]          SIZE_NAT    = 3'($clog2(BYTES));
  localparam logic [63:0]         WIN_BYTES   = 64'(MEM_DEPTH) * 64'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BYTES);
  localparam logic [1:0]          BURST_FIXED = 2'b00;
  localparam logic [1:0]          BURST_INCR  = 2'b01;
  localparam logic [1:0]          RESP_OKAY   = 2'b00;
  localparam logic [1:0]          RESP_SLVERR = 2'b10;

`ifdef EASYAXI_SLV_RD_DELAY_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_e;
  localparam int             LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RESP = 2'd2} state_e;
  // First-beat delay is not used in this build.
  localparam int unsigned rd_latency_unused = RD_LATENCY;
`endif

  // Legality is judged per beat, so a burst may run off the window top.
  function automatic logic beat_legal(input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [2:0]            size,
                                      input logic [1:0]            burst);
    logic in_win;
    logic size_ok;
    logic burst_ok;
    in_win   = (64'(addr) < WIN_BYTES);
    size_ok  = (size == SIZE_NAT);
    burst_ok = (burst == BURST_FIXED) || (burst == BURST_INCR);
    return in_win && size_ok && burst_ok;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] beat_rdata(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [2:0]            size,
                                                       input logic [1:0]            burst);
    return beat_legal(addr, size, burst) ? DATA_WIDTH'(addr) : {DATA_WIDTH{1'b0}};
  endfunction

  function automatic logic [1:0] beat_rresp(input logic [ADDR_WIDTH-1:0] addr,
                                            input logic [2:0]            size,
                                            input logic [1:0]            burst);
    return beat_legal(addr, size, burst) ? RESP_OKAY : RESP_SLVERR;
  endfunction

  state_e                state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] nxt_addr_s;
`ifdef EASYAXI_SLV_RD_DELAY_EN
  logic [LAT_W-1:0]      lat_q, lat_d;
`endif

  // FIXED bursts stay put; WRAP/reserved never return data, so hold too.
  assign nxt_addr_s = (burst_q == BURST_INCR) ? (addr_q + ADDR_STEP) : addr_q;

  // Next-state and next-output logic for the responder FSM.
  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    size_d    = size_q;
    burst_d   = burst_q;
`ifdef EASYAXI_SLV_RD_DELAY_EN
    lat_d     = lat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        if (axi_mst_arvalid && arready_q) begin
          arready_d = 1'b0;
          rid_d     = axi_mst_arid;
          addr_d    = axi_mst_araddr;
          len_d     = axi_mst_arlen;
          size_d    = axi_mst_arsize;
          burst_d   = axi_mst_arburst;
          cnt_d     = 8'd0;
`ifdef EASYAXI_SLV_RD_DELAY_EN
          state_d   = ST_WAIT;
          lat_d     = {LAT_W{1'b0}};
`else
          state_d   = ST_RESP;
          rvalid_d  = 1'b1;
          rlast_d   = (axi_mst_arlen == 8'd0);
          rdata_d   = beat_rdata(axi_mst_araddr, axi_mst_arsize, axi_mst_arburst);
          rresp_d   = beat_rresp(axi_mst_araddr, axi_mst_arsize, axi_mst_arburst);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef EASYAXI_SLV_RD_DELAY_EN
      ST_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d  = ST_RESP;
          rvalid_d = 1'b1;
          rlast_d  = (len_q == 8'd0);
          rdata_d  = beat_rdata(addr_q, size_q, burst_q);
          rresp_d  = beat_rresp(addr_q, size_q, burst_q);
        end else begin
          lat_d = lat_q + {{(LAT_W-1){1'b0}}, 1'b1};
        end
      end
`endif
      ST_RESP: begin
        if (rvalid_q && axi_mst_rready) begin
          if (cnt_q == len_q) begin
            state_d   = ST_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            cnt_d     = 8'd0;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            addr_d  = nxt_addr_s;
            rlast_d = ((cnt_q + 8'd1) == len_q);
            rdata_d = beat_rdata(nxt_addr_s, size_q, burst_q);
            rresp_d = beat_rresp(nxt_addr_s, size_q, burst_q);
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= {ID_WIDTH{1'b0}};
      rdata_q   <= {DATA_WIDTH{1'b0}};
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
      addr_q    <= {ADDR_WIDTH{1'b0}};
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'b00;
`ifdef EASYAXI_SLV_RD_DELAY_EN
      lat_q     <= {LAT_W{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
`ifdef EASYAXI_SLV_RD_DELAY_EN
      lat_q     <= lat_d;
`endif
    end
  end

  assign axi_mst_arready = arready_q;
  assign axi_mst_rvalid  = rvalid_q;
  assign axi_mst_rid     = rid_q;
  assign axi_mst_rdata   = rdata_q;
  assign axi_mst_rresp   = rresp_q;
  assign axi_mst_rlast   = rlast_q;

endmodule
